// File: rtl/rshift_pkg.sv
// Shared definitions for the serial right shifter: FSM states and default sizes.
package rshift_pkg;

    localparam int RSHIFT_WIDTH   = 32;
    localparam int RSHIFT_SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_rshifter.sv
// Serial right shifter: shifts the captured operand one bit per clock.
// Optional feature macro RSHIFT_ARITH_EN: when defined, arith=1 selects
// sign-fill; when undefined, the fill is always zero and arith is ignored.
module serial_rshifter
    import rshift_pkg::*;
#(
    parameter int WIDTH   = RSHIFT_WIDTH,
    parameter int SHAMT_W = RSHIFT_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               arith,
    input  logic [WIDTH-1:0]   In,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   Out,
    output logic               busy,
    output logic               done
);

`ifdef RSHIFT_ARITH_EN
    localparam logic ARITH_EN = 1'b1;
`else
    localparam logic ARITH_EN = 1'b0;
`endif

    localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

    state_t             state;
    state_t             stateNext;
    logic [SHAMT_W-1:0] cnt;
    logic               arithMode;
    logic               fillBit;

    // Bit shifted into the MSB: the current sign bit in arithmetic mode, else zero.
    assign fillBit = ARITH_EN & arithMode & Out[WIDTH-1];

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic; a zero shift amount goes straight to DONE.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = (shamt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (cnt == CNT_ONE) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Operand capture, one-bit-per-cycle shift and remaining-shift counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            Out       <= '0;
            cnt       <= '0;
            arithMode <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        Out       <= In;
                        cnt       <= shamt;
                        arithMode <= arith;
                    end
                end
                SHIFT: begin
                    Out <= {fillBit, Out[WIDTH-1:1]};
                    cnt <= cnt - CNT_ONE;
                end
                default: begin
                    Out <= Out;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_rshifter.sv
// Self-checking bench for serial_rshifter using an expected-result queue.
// Honors RSHIFT_ARITH_EN the same way the design does.
module tb_serial_rshifter;

    typedef struct {
        int          startEdge;
        int          doneEdge;
        logic [31:0] result;
    } expect_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        arith = 1'b0;
    logic [31:0] In = '0;
    logic [4:0]  shamt = '0;
    logic [31:0] Out;
    logic        busy;
    logic        done;

    expect_t     scoreQ[$];
    int          cycle = 0;
    int          total = 0;
    int          bad = 0;
    logic        rstSampled = 1'b0;
    logic [31:0] lastOut = '0;
    logic        expBusy;
    logic        expDone;

    serial_rshifter dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .arith (arith),
        .In    (In),
        .shamt (shamt),
        .Out   (Out),
        .busy  (busy),
        .done  (done)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Edge counter and record of whether reset was applied at the last edge.
    always @(posedge clk) begin
        cycle      <= cycle + 1;
        rstSampled <= rst;
    end

    function automatic logic [31:0] modelShift(input logic [31:0] v, input int sh, input logic ar);
        logic [31:0] r;
        r = v >> sh;
`ifdef RSHIFT_ARITH_EN
        if (ar) begin
            r = 32'($signed(v) >>> sh);
        end
`endif
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // Monitor: compares busy/done every cycle, the result on done, and held output while idle.
    always @(negedge clk) begin
        if (rstSampled) begin
            scoreQ.delete();
            lastOut = '0;
            checkOutput("rst_busy", {31'b0, busy}, 32'd0);
            checkOutput("rst_done", {31'b0, done}, 32'd0);
            checkOutput("rst_out", Out, 32'd0);
        end else begin
            expBusy = (scoreQ.size() > 0) && (cycle >= scoreQ[0].startEdge);
            expDone = (scoreQ.size() > 0) && (cycle == scoreQ[0].doneEdge);
            checkOutput("busy", {31'b0, busy}, {31'b0, expBusy});
            checkOutput("done", {31'b0, done}, {31'b0, expDone});
            if (expDone) begin
                checkOutput("result", Out, scoreQ[0].result);
                lastOut = scoreQ[0].result;
                void'(scoreQ.pop_front());
            end else if (!expBusy) begin
                checkOutput("hold", Out, lastOut);
            end
        end
    end

    // Start one operation (DUT must be idle), push its expectation, then scramble inputs.
    task automatic applyStimulus(input logic [31:0] v, input int sh, input logic ar, output int k);
        expect_t e;
        @(posedge clk);
        #2;
        In    = v;
        shamt = sh[4:0];
        arith = ar;
        start = 1'b1;
        k           = cycle + 1;
        e.startEdge = k;
        e.doneEdge  = k + sh;
        e.result    = modelShift(v, sh, ar);
        scoreQ.push_back(e);
        @(posedge clk);
        #2;
        start = 1'b0;
        In    = $urandom;
        shamt = 5'($urandom_range(0, 31));
        arith = 1'($urandom_range(0, 1));
    endtask

    // Drive start high for exactly the given edge, without expecting acceptance.
    task automatic pokeStart(input int edgeNum);
        while (cycle < edgeNum - 1) begin
            @(posedge clk);
            #2;
        end
        In    = 32'h1234_5678;
        shamt = 5'd3;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    // Wait until the expectation queue drains and the DUT is idle, with a cycle budget.
    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while ((scoreQ.size() != 0 || busy !== 1'b0) && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= budget) begin
            checkOutput("timeout", 32'd1, 32'd0);
        end
    endtask

    initial begin
        int k;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        $display("[TB] zero shift");
        applyStimulus(32'hFFFF_FFFF, 0, 1'b0, k);
        waitIdle(50);

        $display("[TB] logical shift");
        applyStimulus(32'h8000_0000, 4, 1'b0, k);
        waitIdle(50);

        $display("[TB] arithmetic shift");
        applyStimulus(32'h8000_0000, 4, 1'b1, k);
        waitIdle(50);

        $display("[TB] maximum shift");
        applyStimulus(32'h8000_0001, 31, 1'b1, k);
        waitIdle(80);
        applyStimulus(32'h8000_0001, 31, 1'b0, k);
        waitIdle(80);

        $display("[TB] start while busy");
        applyStimulus(32'hF0F0_0F0F, 8, 1'b1, k);
        pokeStart(k + 3);
        pokeStart(k + 9);
        waitIdle(50);
        repeat (3) @(posedge clk);
        #2;

        $display("[TB] reset mid-operation");
        applyStimulus(32'hC000_0003, 10, 1'b1, k);
        while (cycle < k + 1) begin
            @(posedge clk);
            #2;
        end
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        applyStimulus(32'hA5A5_5A5A, 5, 1'b1, k);
        waitIdle(50);

        $display("[TB] random operations");
        for (int i = 0; i < 8; i++) begin
            applyStimulus($urandom, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), k);
            waitIdle(80);
        end

        repeat (3) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_rshifter.md
SERIAL_RSHIFTER -- requirements
Module: serial_rshifter

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; the clock port is named clk and the reset port is named rst.
REQ-002 Parameter WIDTH SHALL default to 32 and set the data width.
REQ-003 Parameter SHAMT_W SHALL default to 5 (clog2 of WIDTH) and set the shift-amount width.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  request a shift; sampled only in IDLE.
REQ-007 arith  input  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill).
REQ-008 In  input  WIDTH  operand.
REQ-009 shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
REQ-010 Out  output  WIDTH  result register.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 done  output  1  one-cycle pulse when Out holds the final result.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-014 IDLE with start=1 at edge k: capture In into Out; capture shamt into a down-counter; capture the fill mode; go to SHIFT if shamt!=0, else go to DONE.
REQ-015 In SHIFT, each edge SHALL right-shift Out by one bit and decrement the counter.
- MSB fill = Out[WIDTH-1] when the fill mode is arithmetic, else 0.
- Go to DONE on the edge where the counter reaches 0.
REQ-016 done SHALL be high only in the cycle following edge k+shamt, for every shamt including 0.
REQ-017 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-018 Out SHALL hold the final result from DONE until the next accepted start.
REQ-019 start SHALL be ignored while busy=1, including during the DONE cycle; no queuing.
REQ-020 In, shamt and arith changes after capture SHALL NOT affect the operation in progress.
REQ-021 The result SHALL equal In>>shamt (logical) or In>>>shamt (arithmetic).

Reset
REQ-022 While rst=1 at an edge, the state SHALL become IDLE, with Out=0, busy=0, done=0 and counter=0.
REQ-023 Reset SHALL override start and SHALL abort any in-progress shift with no done pulse.

Configuration
REQ-024 Macro RSHIFT_ARITH_EN defined: arith SHALL select sign-fill as in REQ-015.
REQ-025 Macro RSHIFT_ARITH_EN undefined: arith SHALL be ignored and the fill SHALL always be 0; the port list is unchanged.

Structure
REQ-026 Package rshift_pkg SHALL hold the state enum (IDLE/SHIFT/DONE), RSHIFT_WIDTH=32 and RSHIFT_SHAMT_W=5.
REQ-027 The block SHALL be a single module with no sub-modules; the FSM, counter and shift register are all internal.

Verification
REQ-028 Zero shift: rst 2 cycles; start, In=0xFFFF_FFFF, shamt=0 at edge k -> done=1 after edge k, Out=0xFFFF_FFFF, busy low after edge k+1.
REQ-029 Logical shift: In=0x8000_0000, shamt=4, arith=0 -> done after edge k+4, Out=0x0800_0000, done exactly 1 cycle wide.
REQ-030 Arithmetic shift: In=0x8000_0000, shamt=4, arith=1 -> Out=0xF800_0000 with RSHIFT_ARITH_EN; Out=0x0800_0000 without it.
REQ-031 Maximum shift: In=0x8000_0001, shamt=31 -> arith=1 gives 0xFFFF_FFFF after edge k+31; arith=0 gives 0x0000_0001.
REQ-032 Start while busy: start with In=0x1234_5678 during SHIFT and during DONE -> ignored, first result unchanged.
REQ-033 Reset mid-operation: rst at edge k+2 of a shamt=10 shift -> Out=0, busy=0, no done pulse; a new start then completes normally.
